unsign_addsub_accum: RTL and testbench
======================================

Name: unsign_addsub_accum

Overview:
- Downstream stage of the unsigned add/sub unit.
- Consumes its registered sum and difference results as a valid-qualified stream and accumulates a programmed number of samples into two wide accumulators (sum lane, difference lane).
- Presents the totals through a valid/ready output handshake, with a sticky overflow flag.
- The upstream controller delays its operand valid by one cycle to align it with the add/sub's 1-cycle result latency.

Parameters:
- INPUT_BIT_WIDTH, 8, width of incoming sum/difference samples
- ACC_BIT_WIDTH, 16, accumulator width; must be >= INPUT_BIT_WIDTH
- COUNT_BIT_WIDTH, 8, width of the sample-count field

Ports:
- Clk  in  1  clock, all logic on rising edge
- RstN  in  1  synchronous active-low reset
- Start  in  1  begin an accumulation run (honoured only in IDLE)
- Count  in  COUNT_BIT_WIDTH  samples per run, latched on accepted Start
- InValid  in  1  InSum/InDiff valid this cycle
- InSum  in  INPUT_BIT_WIDTH  sum sample from add/sub stage
- InDiff  in  INPUT_BIT_WIDTH  difference sample (unsigned, already wrapped mod 2^INPUT_BIT_WIDTH)
- InReady  out  1  block accepts a sample this cycle
- OutValid  out  1  totals available
- OutReady  in  1  consumer takes totals
- SumAcc  out  ACC_BIT_WIDTH  accumulated sum lane
- DiffAcc  out  ACC_BIT_WIDTH  accumulated difference lane
- Overflow  out  1  sticky, either lane exceeded 2^ACC_BIT_WIDTH-1 this run
- Busy  out  1  high in ACCUM or DONE

Behaviour:
- Interface: one clock, Clk; reset RstN is synchronous and active-low.
- Reset (RstN=0 at a rising edge): state=IDLE; SumAcc, DiffAcc, Overflow, OutValid, Busy, remaining-counter all 0. This applies in any state, including mid-run; the partial run is discarded.
- All outputs are registered or decoded from the registered state only. InReady=1 iff state==ACCUM. OutValid=1 iff state==DONE. No combinational path from inputs to outputs.
- IDLE:
  - Start=1 latches Count into the remaining-counter and clears SumAcc, DiffAcc and Overflow.
  - Next state is ACCUM if Count!=0. If Count==0, next state is DONE with zero totals.
  - SumAcc, DiffAcc and Overflow otherwise hold the last run's values.
- ACCUM:
  - A sample is accepted when InValid & InReady.
  - On accept: SumAcc += zero-extended InSum; DiffAcc += zero-extended InDiff; remaining -= 1.
  - If remaining==1 at the accept, next state is DONE. Totals include the final sample and OutValid rises on the cycle after the last accept.
  - InValid=0 stalls without any state change. Start is ignored.
- DONE:
  - Outputs are held stable while OutValid=1 and OutReady=0. Start and InValid are ignored.
  - OutValid & OutReady moves the block to IDLE next cycle. Totals stay readable in IDLE.
- Arithmetic:
  - Each lane adds in ACC_BIT_WIDTH+1 bits.
  - A carry-out sets Overflow (sticky until the next accepted Start or reset).
  - Default result is wrap-around mod 2^ACC_BIT_WIDTH.
- Simultaneous events: reset dominates everything. A Start arriving on the same cycle as the DONE handshake is ignored; a new Start is honoured from IDLE only.
- Throughput: 1 sample/cycle in ACCUM. Run latency is Count accept cycles + 1 to OutValid.

Optional Feature:
- Macro: UNSIGN_ADDSUB_ACCUM_SAT_EN
- Defined: each lane saturates at 2^ACC_BIT_WIDTH-1 on carry-out and stays there for the rest of the run. Overflow is still set.
- Undefined: each lane wraps mod 2^ACC_BIT_WIDTH. Overflow is set as above.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, ACCUM=2'd1, DONE=2'd2
  - default width constants shared with the add/sub stage and its upstream operand controller
- One sub-module, unsign_acc_lane: clear/enable-controlled accumulator with zero-extension, carry detect and optional saturation. Instantiated twice (sum lane, diff lane).
- The FSM and remaining-counter stay in the top module.

Test Plan:
- Basic run, defaults: Start with Count=3; samples (InSum,InDiff) = (10,250), (20,5), (30,1), one per cycle. Required: SumAcc=60, DiffAcc=256, Overflow=0, OutValid high exactly 1 cycle after the third accept.
- Stall: same run with InValid low 4 cycles between samples 1 and 2. Required: identical totals; InReady held high; no spurious count.
- Overflow, ACC_BIT_WIDTH=9: Count=3, InSum=200 x3. Required without the macro: SumAcc=88, Overflow=1. Required with the macro: SumAcc=511, Overflow=1.
- Count=0 and backpressure:
  - Start with Count=0. Required: OutValid next cycle, totals 0.
  - Hold OutReady low 5 cycles and pulse Start during them. Required: outputs stable, Start ignored.
  - Raise OutReady. Required: IDLE next cycle.
- Reset mid-run: RstN low for 1 cycle after 2 of 5 samples. Required: next cycle all outputs 0, InReady=0, IDLE. A fresh run with Count=1 and sample (7,9) gives SumAcc=7, DiffAcc=9.

Source files
------------

// File: rtl/unsign_addsub_accum_pkg.sv
// Shared definitions for the unsigned add/sub datapath: FSM state encoding and default widths
// used by the add/sub stage, its operand controller and this accumulator.
package unsign_addsub_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_INPUT_BIT_WIDTH = 8;
  localparam int DEF_ACC_BIT_WIDTH   = 16;
  localparam int DEF_COUNT_BIT_WIDTH = 8;

endpackage

// File: rtl/unsign_addsub_accum_if.sv
// Sample stream, run control and result handshake of the add/sub accumulator.
// master = the driving controller/consumer side, slave = the accumulator.
interface unsign_addsub_accum_if
  import unsign_addsub_accum_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH = DEF_INPUT_BIT_WIDTH,
  parameter int ACC_BIT_WIDTH   = DEF_ACC_BIT_WIDTH,
  parameter int COUNT_BIT_WIDTH = DEF_COUNT_BIT_WIDTH
) ();

  logic                       Start;
  logic [COUNT_BIT_WIDTH-1:0] Count;
  logic                       InValid;
  logic [INPUT_BIT_WIDTH-1:0] InSum;
  logic [INPUT_BIT_WIDTH-1:0] InDiff;
  logic                       InReady;
  logic                       OutValid;
  logic                       OutReady;
  logic [ACC_BIT_WIDTH-1:0]   SumAcc;
  logic [ACC_BIT_WIDTH-1:0]   DiffAcc;
  logic                       Overflow;
  logic                       Busy;

  modport master (
    output Start, Count, InValid, InSum, InDiff, OutReady,
    input  InReady, OutValid, SumAcc, DiffAcc, Overflow, Busy
  );

  modport slave (
    input  Start, Count, InValid, InSum, InDiff, OutReady,
    output InReady, OutValid, SumAcc, DiffAcc, Overflow, Busy
  );

endinterface

// File: rtl/unsign_acc_lane.sv
// One accumulator lane: zero-extends each enabled sample, adds with carry detect, sticky overflow.
// Saturates at all-ones instead of wrapping when UNSIGN_ADDSUB_ACCUM_SAT_EN is defined.
module unsign_acc_lane #(
  parameter int INPUT_BIT_WIDTH = 8,
  parameter int ACC_BIT_WIDTH   = 16
) (
  input  logic                       Clk,
  input  logic                       RstN,
  input  logic                       Clear,
  input  logic                       Enable,
  input  logic [INPUT_BIT_WIDTH-1:0] Sample,
  output logic [ACC_BIT_WIDTH-1:0]   Acc,
  output logic                       Ovf
);

  logic [ACC_BIT_WIDTH:0] sum_ext;

  assign sum_ext = {1'b0, Acc} + {{(ACC_BIT_WIDTH + 1 - INPUT_BIT_WIDTH){1'b0}}, Sample};

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      Acc <= '0;
      Ovf <= 1'b0;
    end else if (Clear) begin
      Acc <= '0;
      Ovf <= 1'b0;
    end else if (Enable) begin
      if (sum_ext[ACC_BIT_WIDTH]) begin
        Ovf <= 1'b1;
      end
`ifdef UNSIGN_ADDSUB_ACCUM_SAT_EN
      // Once saturated the lane is pinned for the rest of the run.
      if (sum_ext[ACC_BIT_WIDTH] || Ovf) begin
        Acc <= '1;
      end else begin
        Acc <= sum_ext[ACC_BIT_WIDTH-1:0];
      end
`else
      Acc <= sum_ext[ACC_BIT_WIDTH-1:0];
`endif
    end
  end

endmodule

// File: rtl/unsign_addsub_accum.sv
// Accumulates Count sum/diff samples (1/cycle); OutValid one cycle after the last accept, held until OutReady.
// Optional lane saturation via UNSIGN_ADDSUB_ACCUM_SAT_EN; all outputs decode registered state only.
module unsign_addsub_accum
  import unsign_addsub_accum_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH = DEF_INPUT_BIT_WIDTH,
  parameter int ACC_BIT_WIDTH   = DEF_ACC_BIT_WIDTH,
  parameter int COUNT_BIT_WIDTH = DEF_COUNT_BIT_WIDTH
) (
  input logic                   Clk,
  input logic                   RstN,
  unsign_addsub_accum_if.slave  bus
);

  state_t                     state_q;
  state_t                     state_d;
  logic [COUNT_BIT_WIDTH-1:0] remaining_q;
  logic                       start_run;
  logic                       accept;
  logic                       sum_ovf;
  logic                       diff_ovf;

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          start_run = 1'b1;
          state_d   = (bus.Count != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (bus.InValid) begin
          accept = 1'b1;
          if (remaining_q == COUNT_BIT_WIDTH'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.OutReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      remaining_q <= '0;
    end else if (start_run) begin
      remaining_q <= bus.Count;
    end else if (accept) begin
      remaining_q <= remaining_q - COUNT_BIT_WIDTH'(1);
    end
  end

  unsign_acc_lane #(
    .INPUT_BIT_WIDTH (INPUT_BIT_WIDTH),
    .ACC_BIT_WIDTH   (ACC_BIT_WIDTH)
  ) u_sum_lane (
    .Clk    (Clk),
    .RstN   (RstN),
    .Clear  (start_run),
    .Enable (accept),
    .Sample (bus.InSum),
    .Acc    (bus.SumAcc),
    .Ovf    (sum_ovf)
  );

  unsign_acc_lane #(
    .INPUT_BIT_WIDTH (INPUT_BIT_WIDTH),
    .ACC_BIT_WIDTH   (ACC_BIT_WIDTH)
  ) u_diff_lane (
    .Clk    (Clk),
    .RstN   (RstN),
    .Clear  (start_run),
    .Enable (accept),
    .Sample (bus.InDiff),
    .Acc    (bus.DiffAcc),
    .Ovf    (diff_ovf)
  );

  assign bus.Overflow = sum_ovf | diff_ovf;
  assign bus.InReady  = (state_q == ACCUM);
  assign bus.OutValid = (state_q == DONE);
  assign bus.Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_unsign_addsub_accum.sv
// Bench for unsign_addsub_accum: a 16-bit and a 9-bit accumulator instance driven with the same stream,
// checked against table expectations and a totals-based reference model.
module tb_unsign_addsub_accum;

`ifdef UNSIGN_ADDSUB_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic Clk;
  logic RstN;

  unsign_addsub_accum_if #(.INPUT_BIT_WIDTH(8), .ACC_BIT_WIDTH(16), .COUNT_BIT_WIDTH(8)) bus ();
  unsign_addsub_accum_if #(.INPUT_BIT_WIDTH(8), .ACC_BIT_WIDTH(9),  .COUNT_BIT_WIDTH(8)) bus9 ();

  assign bus9.Start    = bus.Start;
  assign bus9.Count    = bus.Count;
  assign bus9.InValid  = bus.InValid;
  assign bus9.InSum    = bus.InSum;
  assign bus9.InDiff   = bus.InDiff;
  assign bus9.OutReady = bus.OutReady;

  unsign_addsub_accum #(.INPUT_BIT_WIDTH(8), .ACC_BIT_WIDTH(16), .COUNT_BIT_WIDTH(8)) dut (
    .Clk  (Clk),
    .RstN (RstN),
    .bus  (bus)
  );

  unsign_addsub_accum #(.INPUT_BIT_WIDTH(8), .ACC_BIT_WIDTH(9), .COUNT_BIT_WIDTH(8)) dut9 (
    .Clk  (Clk),
    .RstN (RstN),
    .bus  (bus9)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int    checks = 0;
  int    errors = 0;
  string grp    = "init";
  int    q_sum[$];
  int    q_diff[$];

  typedef struct {
    int              n;
    logic [3:0][7:0] s;
    logic [3:0][7:0] d;
    int              stall1;
    int              es16, ed16;
    int              es9w, ed9w, es9s, ed9s, eo9;
  } vec_t;

  vec_t tbl[5];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d, expected %0d", grp, nm, act, exp);
    end
  endtask

  // Reference: a lane's result depends only on the true total of the run.
  function automatic int lane_model(input int total, input int aw);
    if (SAT) return (total >= (1 << aw)) ? (1 << aw) - 1 : total;
    return total % (1 << aw);
  endfunction

  task automatic chk_idle_zero();
    chk("sum16", bus.SumAcc, 0);   chk("diff16", bus.DiffAcc, 0);  chk("ovf16", bus.Overflow, 0);
    chk("sum9", bus9.SumAcc, 0);   chk("diff9", bus9.DiffAcc, 0);  chk("ovf9", bus9.Overflow, 0);
    chk("outvalid", bus.OutValid, 0); chk("inready", bus.InReady, 0); chk("busy", bus.Busy, 0);
    chk("busy9", bus9.Busy, 0);
  endtask

  // Runs q_sum/q_diff through both instances; stall1 idles before sample 1, rstall adds random gaps.
  task automatic run(input int n, input int stall1, input int rstall,
                     input int es16, input int ed16, input int eo16,
                     input int es9, input int ed9, input int eo9);
    int st;
    int bp;
    chk("pre_busy", bus.Busy, 0);
    bus.Count = 8'(n);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    chk("busy", bus.Busy, 1);
    chk("inready", bus.InReady, 1);
    for (int i = 0; i < n; i++) begin
      st = ((i == 1) ? stall1 : 0) + int'($urandom_range(0, rstall));
      for (int k = 0; k < st; k++) begin
        bus.InValid = 1'b0;
        bus.InSum   = 8'($urandom);
        bus.InDiff  = 8'($urandom);
        step();
        chk("stall_inready", bus.InReady, 1);
      end
      chk("early_outvalid", bus.OutValid, 0);
      bus.InValid = 1'b1;
      bus.InSum   = 8'(q_sum[i]);
      bus.InDiff  = 8'(q_diff[i]);
      step();
    end
    bus.InValid = 1'b0;
    chk("outvalid", bus.OutValid, 1);   chk("outvalid9", bus9.OutValid, 1);
    chk("inready_done", bus.InReady, 0);
    chk("sum16", bus.SumAcc, es16);     chk("diff16", bus.DiffAcc, ed16); chk("ovf16", bus.Overflow, eo16);
    chk("sum9", bus9.SumAcc, es9);      chk("diff9", bus9.DiffAcc, ed9);  chk("ovf9", bus9.Overflow, eo9);
    bp = int'($urandom_range(0, 3));
    for (int k = 0; k < bp; k++) begin
      bus.InValid = 1'b1;
      step();
      chk("bp_outvalid", bus.OutValid, 1);
      chk("bp_sum9", bus9.SumAcc, es9);
    end
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b1;
    step();
    bus.OutReady = 1'b0;
    chk("post_outvalid", bus.OutValid, 0);
    chk("post_busy", bus.Busy, 0);
    chk("held_sum16", bus.SumAcc, es16);
    chk("held_diff9", bus9.DiffAcc, ed9);
  endtask

  initial begin
    int ts;
    int td;

    tbl[0] = '{3, {8'd0, 8'd30, 8'd20, 8'd10}, {8'd0, 8'd1, 8'd5, 8'd250}, 0,
               60, 256, 60, 256, 60, 256, 0};
    tbl[1] = '{3, {8'd0, 8'd30, 8'd20, 8'd10}, {8'd0, 8'd1, 8'd5, 8'd250}, 4,
               60, 256, 60, 256, 60, 256, 0};
    tbl[2] = '{3, {8'd0, 8'd200, 8'd200, 8'd200}, {8'd0, 8'd0, 8'd0, 8'd0}, 0,
               600, 0, 88, 0, 511, 0, 1};
    tbl[3] = '{4, {8'd255, 8'd255, 8'd255, 8'd255}, {8'd255, 8'd255, 8'd255, 8'd255}, 0,
               1020, 1020, 508, 508, 511, 511, 1};
    tbl[4] = '{1, {8'd0, 8'd0, 8'd0, 8'd7}, {8'd0, 8'd0, 8'd0, 8'd9}, 0,
               7, 9, 7, 9, 7, 9, 0};

    RstN = 1'b0;
    bus.Start = 1'b0; bus.Count = '0; bus.InValid = 1'b0;
    bus.InSum = '0;   bus.InDiff = '0; bus.OutReady = 1'b0;
    step(); step();
    grp = "reset";
    chk_idle_zero();
    RstN = 1'b1;
    step();

    for (int v = 0; v < 5; v++) begin
      grp = $sformatf("vec%0d", v);
      q_sum.delete(); q_diff.delete();
      for (int i = 0; i < tbl[v].n; i++) begin
        q_sum.push_back(int'(tbl[v].s[i]));
        q_diff.push_back(int'(tbl[v].d[i]));
      end
      run(tbl[v].n, tbl[v].stall1, 0, tbl[v].es16, tbl[v].ed16, 0,
          SAT ? tbl[v].es9s : tbl[v].es9w, SAT ? tbl[v].ed9s : tbl[v].ed9w, tbl[v].eo9);
    end

    // Count=0 run, backpressure with a Start in DONE, Start coincident with the handshake.
    grp = "count0";
    bus.Count = 8'd0;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    chk("outvalid", bus.OutValid, 1); chk("busy", bus.Busy, 1); chk("inready", bus.InReady, 0);
    chk("sum16", bus.SumAcc, 0); chk("diff16", bus.DiffAcc, 0); chk("ovf9", bus9.Overflow, 0);
    for (int k = 0; k < 5; k++) begin
      bus.Count = 8'd5;
      bus.Start = (k == 2);
      step();
      chk("bp_outvalid", bus.OutValid, 1);
      chk("bp_sum", bus.SumAcc, 0);
    end
    bus.Start    = 1'b1;
    bus.OutReady = 1'b1;
    step();
    bus.Start    = 1'b0;
    bus.OutReady = 1'b0;
    chk("hs_outvalid", bus.OutValid, 0);
    chk("hs_busy", bus.Busy, 0);
    step();
    chk("idle_busy", bus.Busy, 0);

    // Reset in the middle of a run discards the partial totals.
    grp = "midreset";
    bus.Count = 8'd5;
    bus.Start = 1'b1;
    step();
    bus.Start   = 1'b0;
    bus.InValid = 1'b1; bus.InSum = 8'd200; bus.InDiff = 8'd150;
    step();
    bus.InSum = 8'd250; bus.InDiff = 8'd220;
    step();
    chk("partial_sum16", bus.SumAcc, 450);
    bus.InValid = 1'b0;
    RstN = 1'b0;
    step();
    RstN = 1'b1;
    chk_idle_zero();
    step();
    chk("after_busy", bus.Busy, 0);
    grp = "fresh";
    q_sum = '{7}; q_diff = '{9};
    run(1, 0, 0, 7, 9, 0, 7, 9, 0);

    for (int r = 0; r < 25; r++) begin
      int n;
      grp = $sformatf("rnd%0d", r);
      n = int'($urandom_range(1, 12));
      q_sum.delete(); q_diff.delete();
      ts = 0; td = 0;
      for (int i = 0; i < n; i++) begin
        q_sum.push_back(int'($urandom_range(0, 255)));
        q_diff.push_back(int'($urandom_range(0, 255)));
        ts += q_sum[i];
        td += q_diff[i];
      end
      run(n, 0, 2, lane_model(ts, 16), lane_model(td, 16), int'(ts >= 65536 || td >= 65536),
          lane_model(ts, 9), lane_model(td, 9), int'(ts >= 512 || td >= 512));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
